// File: rtl/mech_pkg.sv
// Shared mechanism-layer definitions: props word layout, lift FSM states and
// the props packer reused by the player, terrain and lift blocks.
package mech_pkg;

    localparam int PROPS_W      = 40;
    localparam int PROP_FIELD_W = 10;

    // Field LSB positions inside the props word, {x, y, w, h} MSB first.
    localparam int PROP_X = 30;
    localparam int PROP_Y = 20;
    localparam int PROP_W = 10;
    localparam int PROP_H = 0;

    typedef enum logic [2:0] {
        LIFT_BOTTOM,
        LIFT_RISE,
        LIFT_TOP,
        LIFT_HOLD,
        LIFT_FALL
    } lift_state_t;

    function automatic logic [PROPS_W-1:0] pack_props(
        input logic [PROP_FIELD_W-1:0] x,
        input logic [PROP_FIELD_W-1:0] y,
        input logic [PROP_FIELD_W-1:0] w,
        input logic [PROP_FIELD_W-1:0] h
    );
        logic [PROPS_W-1:0] p;
        p = '0;
        p[PROP_X +: PROP_FIELD_W] = x;
        p[PROP_Y +: PROP_FIELD_W] = y;
        p[PROP_W +: PROP_FIELD_W] = w;
        p[PROP_H +: PROP_FIELD_W] = h;
        return p;
    endfunction

endpackage

// File: rtl/lift_ctrl_if.sv
// Lift controller bus: frame pulse, button/blocking inputs and the published
// platform props with status flags.
interface lift_ctrl_if;
    import mech_pkg::*;

    logic               frame_tick;
    logic               btn_p1;
    logic               btn_p2;
    logic               fall_block;
    logic [PROPS_W-1:0] lift_props;
    logic               active;
    logic               moving;
    logic               at_top;
    logic               at_bottom;

    modport master (
        output frame_tick, btn_p1, btn_p2, fall_block,
        input  lift_props, active, moving, at_top, at_bottom
    );

    modport slave (
        input  frame_tick, btn_p1, btn_p2, fall_block,
        output lift_props, active, moving, at_top, at_bottom
    );

endinterface

// File: rtl/lift_ctrl_hold_timer.sv
// Frame-tick enabled down-counter that times the pause at the top before the
// platform descends; the release frame itself counts as the first held frame.
module lift_hold_timer #(
    parameter logic [7:0] HOLD_FRAMES = 8'd30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam logic [7:0] LOAD_VALUE = (HOLD_FRAMES == 8'd0) ? 8'd0 : HOLD_FRAMES - 8'd1;

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            if (load) begin
                count <= LOAD_VALUE;
            end else if (dec && (count != 8'd0)) begin
                count <= count - 8'd1;
            end
        end
    end

    // Done while the current tick is the last frame of the hold window.
    assign done = (count <= 8'd1);

endmodule

// File: rtl/lift_ctrl.sv
// Elevator platform controller: steps between rest positions once per frame.
// Optional lever mode (press toggles target) is enabled by defining LIFT_TOGGLE_EN.
module lift_ctrl
    import mech_pkg::*;
#(
    parameter logic [9:0] X           = 10'd0,
    parameter logic [9:0] Y_BOTTOM    = 10'd400,
    parameter logic [9:0] Y_TOP       = 10'd300,
    parameter logic [9:0] W           = 10'd64,
    parameter logic [9:0] H           = 10'd16,
    parameter logic [3:0] STEP        = 4'd4,
    parameter logic [7:0] HOLD_FRAMES = 8'd30
) (
    input  logic       clk,
    input  logic       rst_n,
    lift_ctrl_if.slave bus
);

    lift_state_t state;
    logic [9:0]  y;
    logic [9:0]  y_next;
    logic [9:0]  y_rise;
    logic [9:0]  y_fall;
    logic [10:0] y_wide;
    logic [10:0] step_wide;
    logic        req_raw;
    logic        req_eff;
    logic        hold_done;
    logic        timer_load;
    logic        timer_dec;

    assign req_raw = bus.btn_p1 | bus.btn_p2;

`ifdef LIFT_TOGGLE_EN
    localparam lift_state_t RELEASE_STATE = LIFT_FALL;

    logic req_q;
    logic target_up;

    // Lever mode: each rising edge of the press flips the target, so the
    // next-cycle target is also what the FSM acts on this tick.
    always_comb req_eff = target_up ^ (req_raw & ~req_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q     <= 1'b0;
            target_up <= 1'b0;
        end else if (bus.frame_tick) begin
            req_q     <= req_raw;
            target_up <= req_eff;
        end
    end

    always_comb begin
        timer_load = 1'b0;
        timer_dec  = 1'b0;
    end
`else
    localparam lift_state_t RELEASE_STATE = LIFT_HOLD;

    always_comb req_eff = req_raw;

    always_comb begin
        timer_load = ((state == LIFT_RISE) || (state == LIFT_TOP)) && !req_eff;
        timer_dec  = (state == LIFT_HOLD) && !req_eff;
    end
`endif

    lift_hold_timer #(
        .HOLD_FRAMES(HOLD_FRAMES)
    ) u_hold_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (bus.frame_tick),
        .load (timer_load),
        .dec  (timer_dec),
        .done (hold_done)
    );

    // Comparisons are done in 11 bits so the clamps never see a wrapped value.
    assign y_wide    = {1'b0, y};
    assign step_wide = {7'd0, STEP};

    always_comb begin
        y_rise = y - {6'd0, STEP};
        if (y_wide < ({1'b0, Y_TOP} + step_wide)) begin
            y_rise = Y_TOP;
        end
        y_fall = y + {6'd0, STEP};
        if ((y_wide + step_wide) >= {1'b0, Y_BOTTOM}) begin
            y_fall = Y_BOTTOM;
        end
    end

    always_comb begin
        y_next = y;
        unique case (state)
            LIFT_RISE: if (req_eff) y_next = y_rise;
            LIFT_FALL: if (!req_eff && !bus.fall_block) y_next = y_fall;
            default:   y_next = y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= LIFT_BOTTOM;
            y              <= Y_BOTTOM;
            bus.active     <= 1'b0;
            bus.moving     <= 1'b0;
            bus.at_top     <= 1'b0;
            bus.at_bottom  <= 1'b1;
            bus.lift_props <= pack_props(X, Y_BOTTOM, W, H);
        end else if (bus.frame_tick) begin
            y              <= y_next;
            bus.active     <= req_eff;
            bus.moving     <= (y_next != y);
            bus.at_top     <= (y_next == Y_TOP);
            bus.at_bottom  <= (y_next == Y_BOTTOM);
            bus.lift_props <= pack_props(X, y_next, W, H);

            unique case (state)
                LIFT_BOTTOM: begin
                    if (req_eff) state <= LIFT_RISE;
                end
                LIFT_RISE: begin
                    if (!req_eff) begin
                        state <= RELEASE_STATE;
                    end else if (y_rise == Y_TOP) begin
                        state <= LIFT_TOP;
                    end
                end
                LIFT_TOP: begin
                    if (!req_eff) state <= RELEASE_STATE;
                end
                LIFT_HOLD: begin
                    if (req_eff) begin
                        state <= (y == Y_TOP) ? LIFT_TOP : LIFT_RISE;
                    end else if (hold_done) begin
                        state <= LIFT_FALL;
                    end
                end
                LIFT_FALL: begin
                    // A press wins over a blocked descent.
                    if (req_eff) begin
                        state <= LIFT_RISE;
                    end else if (!bus.fall_block && (y_fall == Y_BOTTOM)) begin
                        state <= LIFT_BOTTOM;
                    end
                end
                default: state <= LIFT_BOTTOM;
            endcase
        end
    end

endmodule

// File: tb/tb_lift_ctrl.sv
// Scoreboard bench for lift_ctrl: two instances (STEP 4 and STEP 7) share the
// same randomized and directed stimulus and are checked against a frame model.
module tb_lift_ctrl;

    localparam int Y_TOP_I = 300;
    localparam int Y_BOT_I = 400;
    localparam int HOLD_I  = 30;

    typedef struct packed {
        logic [39:0] props;
        logic        active;
        logic        moving;
        logic        at_top;
        logic        at_bottom;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;

    lift_ctrl_if bus_a ();
    lift_ctrl_if bus_b ();

    lift_ctrl dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    lift_ctrl #(
        .STEP(4'd7)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    obs_t exp_a[$];
    obs_t exp_b[$];

    // Frame model: y plus what the platform intends (climbing, waiting, falling).
    int m_y[2];
    bit m_climb[2];
    int m_wait[2];
    bit m_fall[2];
    bit m_active[2];
    bit m_moving[2];
    int m_step[2] = '{4, 7};

    task automatic model_step(input int k, input bit tick, input bit req, input bit blk, input bit rstn);
        int prev_y;
        if (!rstn) begin
            m_y[k]      = Y_BOT_I;
            m_climb[k]  = 1'b0;
            m_wait[k]   = 0;
            m_fall[k]   = 1'b0;
            m_active[k] = 1'b0;
            m_moving[k] = 1'b0;
        end else if (tick) begin
            prev_y = m_y[k];
            if (req) begin
                if (m_climb[k]) begin
                    m_y[k] = (m_y[k] - m_step[k] < Y_TOP_I) ? Y_TOP_I : m_y[k] - m_step[k];
                end else begin
                    m_climb[k] = 1'b1;
                    m_wait[k]  = 0;
                    m_fall[k]  = 1'b0;
                end
            end else if (m_climb[k]) begin
                m_climb[k] = 1'b0;
                m_wait[k]  = HOLD_I - 1;
            end else if (m_wait[k] > 0) begin
                m_wait[k] = m_wait[k] - 1;
                if (m_wait[k] == 0) m_fall[k] = 1'b1;
            end else if (m_fall[k] && !blk) begin
                m_y[k] = (m_y[k] + m_step[k] > Y_BOT_I) ? Y_BOT_I : m_y[k] + m_step[k];
                if (m_y[k] == Y_BOT_I) m_fall[k] = 1'b0;
            end
            m_active[k] = req;
            m_moving[k] = (m_y[k] != prev_y);
        end
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t       o;
        logic [9:0] yv;
        yv          = 10'(m_y[k]);
        o.props     = {10'd0, yv, 10'd64, 10'd16};
        o.active    = m_active[k];
        o.moving    = m_moving[k];
        o.at_top    = (m_y[k] == Y_TOP_I);
        o.at_bottom = (m_y[k] == Y_BOT_I);
        return o;
    endfunction

    task automatic applyStimulus(input bit tick, input bit b1, input bit b2, input bit blk, input bit rstn);
        rst_n            = rstn;
        bus_a.frame_tick = tick;
        bus_a.btn_p1     = b1;
        bus_a.btn_p2     = b2;
        bus_a.fall_block = blk;
        bus_b.frame_tick = tick;
        bus_b.btn_p1     = b1;
        bus_b.btn_p2     = b2;
        bus_b.fall_block = blk;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, tick, b1 | b2, blk, rstn);
        exp_a.push_back(model_obs(0));
        exp_b.push_back(model_obs(1));
        @(negedge clk);
    endtask

    // Ticks with occasional tick-less cycles carrying junk button levels.
    task automatic runTicks(input int n, input bit b1, input bit b2, input bit blk);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0)
                applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            applyStimulus(1'b1, b1, b2, blk, 1'b1);
        end
    endtask

    task automatic checkOutput(input string name, input obs_t e, input obs_t a);
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL %s t=%0t y got=%0d exp=%0d act/mov/top/bot got=%b%b%b%b exp=%b%b%b%b props got=%h exp=%h",
                     name, $time, a.props[29:20], e.props[29:20],
                     a.active, a.moving, a.at_top, a.at_bottom,
                     e.active, e.moving, e.at_top, e.at_bottom, a.props, e.props);
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t e;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checkOutput("dut_a", e, {bus_a.lift_props, bus_a.active, bus_a.moving, bus_a.at_top, bus_a.at_bottom});
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            checkOutput("dut_b", e, {bus_b.lift_props, bus_b.active, bus_b.moving, bus_b.at_top, bus_b.at_bottom});
        end
    end

    initial begin
        bit b1;
        bit b2;
        bit blk;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Full rise, top dwell, full descent.
        runTicks(30, 1'b1, 1'b0, 1'b0);
        runTicks(60, 1'b0, 1'b0, 1'b0);

        // Release mid-rise, re-press from the other player.
        for (int i = 0; i < 40 && m_y[0] != 340; i++) runTicks(1, 1'b1, 1'b0, 1'b0);
        runTicks(5, 1'b0, 1'b0, 1'b0);
        runTicks(3, 1'b0, 1'b1, 1'b0);

        // Blocked descent at 360, then press beats block.
        for (int i = 0; i < 100 && !(m_fall[0] && m_y[0] == 360); i++) runTicks(1, 1'b0, 1'b0, 1'b0);
        runTicks(10, 1'b0, 1'b0, 1'b1);
        runTicks(1, 1'b1, 1'b0, 1'b1);
        runTicks(4, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a descent.
        for (int i = 0; i < 60 && !m_fall[0]; i++) runTicks(1, 1'b0, 1'b0, 1'b0);
        runTicks(3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runTicks(5, 1'b0, 1'b0, 1'b0);

        b1 = 1'b0;
        b2 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (b1) b1 = ($urandom_range(0, 29) != 0);
            else    b1 = ($urandom_range(0, 39) == 0);
            if (b2) b2 = ($urandom_range(0, 9) != 0);
            else    b2 = ($urandom_range(0, 79) == 0);
            blk = ($urandom_range(0, 7) == 0);
            applyStimulus(($urandom_range(0, 3) != 0), b1, b2, blk, ($urandom_range(0, 499) != 0));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if ((exp_a.size() != 0) || (exp_b.size() != 0)) begin
            bad++;
            $display("[TB] FAIL drain left a=%0d b=%0d required=0", exp_a.size(), exp_b.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lift_ctrl.md
# lift_ctrl

Frame-rate controller for one elevator platform in the mechanism layer. Watches the "player standing on button" collision flags of both players and moves the platform between a bottom and a top rest position, one step per video frame. Publishes the platform as a 40-bit props word so terrain collision, player physics and the sprite renderer treat it like any other object.

## Interface
- X, 10'd0: platform left edge, pixels
- Y_BOTTOM, 10'd400: platform top-edge y at rest-low
- Y_TOP, 10'd300: platform top-edge y at rest-high; must be < Y_BOTTOM
- W, 10'd64: platform width
- H, 10'd16: platform height
- STEP, 4'd4: pixels moved per frame, 1..15
- HOLD_FRAMES, 8'd30: frames the platform waits after release before descending

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per VGA frame; all state changes gated by it
- btn_p1  in  1  button collision with player1, level
- btn_p2  in  1  button collision with player2, level
- fall_block  in  1  an object sits under the platform; descent forbidden
- lift_props  out  40  {X, y, W, H}, 10 bits each, MSB first
- active  out  1  registered button-pressed state, drives button sprite
- moving  out  1  platform changed y on the last tick
- at_top  out  1  y == Y_TOP
- at_bottom  out  1  y == Y_BOTTOM

## Operation
- req = btn_p1 | btn_p2, sampled only on edges where frame_tick = 1.
- States: BOTTOM, RISE, TOP, HOLD, FALL. Transitions and y updates happen only on frame_tick edges; otherwise everything holds.
- BOTTOM: req -> RISE (y unchanged this tick).
- RISE: req -> y = max(y - STEP, Y_TOP); on reaching Y_TOP -> TOP. !req -> HOLD, counter loaded.
- TOP: !req -> HOLD, counter loaded.
- HOLD: req -> RISE (or TOP if y == Y_TOP). !req -> counter decrements; at count HOLD_FRAMES elapsed -> FALL.
- FALL: req -> RISE (press beats block). fall_block -> y holds, stay FALL, moving = 0. Else y = min(y + STEP, Y_BOTTOM); on reaching Y_BOTTOM -> BOTTOM.
- Arithmetic in 11 bits to avoid wrap; clamp makes endpoints exact for any STEP.
- active = registered req. moving = 1 for ticks where y changed. at_top/at_bottom are derived from the registered y.
- Reset (rst_n = 0 at an edge, any state, mid-motion included): state BOTTOM, y = Y_BOTTOM, hold counter 0, active 0, moving 0, at_top 0, at_bottom 1, lift_props = {X, Y_BOTTOM, W, H}.

## Timing
- All outputs registered; they update on the same clk edge as the frame_tick that causes the change.
- Press to first motion: 2 ticks. Tick 1 enters RISE; tick 2 applies the first step.
- Release at top to first descent: HOLD_FRAMES + 1 ticks. After HOLD_FRAMES ticks, state enters FALL; the next tick applies the first step.
- With the defaults, a full traverse takes ceil(100/4) = 25 stepping ticks.
- lift_props is stable for a whole frame, which makes it safe for the renderer scanning with disp_h/disp_v.

## Configuration
- LIFT_TOGGLE_EN defined: a rising edge of req at a tick toggles an internal target_up register, and the FSM uses target_up in place of req. This is lever mode: the platform stays up until the next press, with no hold delay. active reflects target_up.
- Undefined: momentary behaviour as described above, and no target_up register exists.

## Structure
- Shared mech_pkg:
  - props field slice constants (PROP_X, PROP_Y, PROP_W, PROP_H)
  - lift state enum
  - pack_props function, reused by player and terrain blocks
- One natural sub-module, lift_hold_timer: a loadable down-counter with a done flag, clocked by frame_tick enable.

## Test plan
- Reset with rst_n = 0 for 2 cycles -> lift_props y = 400, at_bottom = 1, active = 0, moving = 0.
- btn_p1 held, 30 frame_ticks -> RISE on tick 1; y = 396 on tick 2; y = 300 and at_top = 1 on tick 26; no change on later ticks.
- Release at top -> y stays 300 for 30 ticks; y = 304 on tick 31; y = 400 and at_bottom = 1 on tick 55.
- Release at y = 340 during RISE, btn_p2 pressed 5 ticks later -> y holds at 340 in HOLD, then RISE resumes, reaching 336 on the next tick.
- In FALL at y = 360, fall_block = 1 for 10 ticks -> y stays 360 and moving = 0. fall_block and btn_p1 together -> RISE.
- With STEP = 7 -> rise sequence 400, 393, …, 302, then 300 (clamped). Also: clk toggled with frame_tick = 0 -> no output changes. Also: reset asserted mid-FALL -> y = 400 on the next edge.
